// File: rtl/sha256_stream_core.sv
// sha256_stream_core: SHA-256/SHA-224 compression engine with block chaining,
// selectable IV, UNROLL rounds per clock and a completed-block counter.
module sha256_stream_core #(
   parameter int UNROLL = 1,
   parameter int CTR_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             first_state,
   input  logic             next_state,
   input  logic             use_ext_iv,
   input  logic             mode,
   input  logic [255:0]     initial_state,
   input  logic [511:0]     message_block,
   output logic             status,
   output logic [255:0]     hash,
   output logic             valid_block,
   output logic [CTR_W-1:0] blocks_done
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
   end

   localparam logic [5:0] T_STEP = 6'(UNROLL);
   localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

   localparam logic [255:0] IV_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [255:0] IV_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   // Round constant ROM, K[0] in the top word.
   localparam logic [2047:0] K_TAB = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUNDS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            st;
   state_t            st_nxt;

   logic [7:0][31:0]  h_q;
   logic [7:0][31:0]  v_q;
   logic [7:0][31:0]  v_nxt;
   logic [15:0][31:0] w_q;
   logic [15:0][31:0] w_nxt;
   logic [7:0][31:0]  iv_w;
   logic [15:0][31:0] msg_w;
   logic [255:0]      iv_sel;
   logic [255:0]      h_flat;
   logic [5:0]        t_q;
   logic [5:0]        ti;
   logic [31:0]       t1;
   logic [31:0]       t2;
   logic [31:0]       nw;
   logic              chain_ok;
   logic              mode_q;
   logic              pend_q;
   logic              ld_first;
   logic              ld_next;
   logic              in_rounds;
   logic              in_done;

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, f, g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, b, c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] t);
      return K_TAB[(63 - int'(t)) * 32 +: 32];
   endfunction

   // Word-order adaptation between the flat buses and indexed registers.
   always_comb begin
      iv_sel = use_ext_iv ? initial_state : (mode ? IV_224 : IV_256);
      for (int i = 0; i < 8; i++) begin
         iv_w[i] = iv_sel[255 - 32*i -: 32];
         h_flat[255 - 32*i -: 32] = h_q[i];
      end
      for (int j = 0; j < 16; j++) begin
         msg_w[j] = message_block[511 - 32*j -: 32];
      end
      if (mode_q) begin
         h_flat[31:0] = '0;
      end
   end

   // UNROLL chained rounds; the window shifts one word per round.
   always_comb begin
      v_nxt = v_q;
      w_nxt = w_q;
      t1    = '0;
      t2    = '0;
      nw    = '0;
      ti    = t_q;
      for (int i = 0; i < UNROLL; i++) begin
         ti = t_q + 6'(i);
         t1 = v_nxt[7] + bsig1(v_nxt[4]) + ch(v_nxt[4], v_nxt[5], v_nxt[6])
            + k_rom(ti) + w_nxt[0];
         t2 = bsig0(v_nxt[0]) + maj(v_nxt[0], v_nxt[1], v_nxt[2]);
         v_nxt = {v_nxt[6], v_nxt[5], v_nxt[4], v_nxt[3] + t1,
                  v_nxt[2], v_nxt[1], v_nxt[0], t1 + t2};
         nw = ssig1(w_nxt[14]) + w_nxt[9] + ssig0(w_nxt[1]) + w_nxt[0];
         w_nxt = {nw, w_nxt[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st <= IDLE;
      end else begin
         st <= st_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      unique case (st)
         IDLE:    if (ld_first || ld_next) st_nxt = ROUNDS;
         ROUNDS:  if (t_q == T_LAST) st_nxt = DONE;
         DONE:    st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      ld_first  = 1'b0;
      ld_next   = 1'b0;
      in_rounds = 1'b0;
      in_done   = 1'b0;
      unique case (1'b1)
         st == IDLE: begin
            ld_first = status && first_state;
            ld_next  = status && !first_state && next_state && chain_ok;
         end
         st == ROUNDS: in_rounds = 1'b1;
         st == DONE:   in_done   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_q         <= '0;
         v_q         <= '0;
         w_q         <= '0;
         t_q         <= '0;
         chain_ok    <= 1'b0;
         mode_q      <= 1'b0;
         pend_q      <= 1'b0;
         status      <= 1'b1;
         valid_block <= 1'b0;
         hash        <= '0;
         blocks_done <= '0;
      end else begin
         // Ready only after a full settled cycle back in IDLE.
         status <= (st == IDLE) && !(ld_first || ld_next);
         if (ld_first) begin
            mode_q      <= mode;
            h_q         <= iv_w;
            v_q         <= iv_w;
            chain_ok    <= 1'b1;
            blocks_done <= '0;
         end else if (ld_next) begin
            v_q <= h_q;
         end
         if (ld_first || ld_next) begin
            w_q         <= msg_w;
            t_q         <= '0;
            valid_block <= 1'b0;
         end
         if (in_rounds) begin
            v_q <= v_nxt;
            w_q <= w_nxt;
            t_q <= t_q + T_STEP;
         end
         if (in_done) begin
            for (int i = 0; i < 8; i++) begin
               h_q[i] <= h_q[i] + v_q[i];
            end
            if (!(&blocks_done)) begin
               blocks_done <= blocks_done + 1'b1;
            end
            pend_q <= 1'b1;
         end
         if (st == IDLE) begin
            hash <= h_flat;
            if (pend_q) begin
               valid_block <= 1'b1;
               pend_q      <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Parametrised SHA-256/SHA-224 compression engine; successor to the single-block math core.
- Adds multi-block chaining (first/next), a selectable external or standard IV, and SHA-224 mode.
- Adds configurable round unrolling and a completed-block counter.
- Sits between the message padder/block buffer and the digest output register bank.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 4, 8; other values are illegal (elaboration assertion).
- CTR_W, 16, width of blocks_done counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- first_state  input  1  start new message; H loaded from IV, then block compressed
- next_state  input  1  compress block chaining from current H
- use_ext_iv  input  1  on first_state: 1 = IV from initial_state, 0 = standard IV for mode
- mode  input  1  0 = SHA-256, 1 = SHA-224; sampled on first_state only
- initial_state  input  256  external IV; H0 in [255:224] … H7 in [31:0]
- message_block  input  512  W0 in [511:480] … W15 in [31:0]
- status  output  1  1 = idle/ready to accept a start
- hash  output  256  digest; H0 in [255:224]
- valid_block  output  1  hash holds a completed-block result
- blocks_done  output  CTR_W  blocks completed since last first_state

Behaviour:
- Reset: when reset_n = 0 at a clock edge, the block takes the following values on that edge:
  - FSM = IDLE; status = 1; valid_block = 0; hash = 0; blocks_done = 0.
  - H0..H7 = 0; chain_ok = 0; latched mode = 0.
  - Reset overrides everything, including an in-flight operation.
- FSM states: IDLE, ROUNDS, DONE.
- IDLE, start acceptance:
  - A start is accepted only in IDLE with status = 1.
  - first_state has priority over next_state if both are high.
  - first_state:
    - latches mode;
    - loads H from the IV (initial_state if use_ext_iv = 1, else the SHA-256 or SHA-224 standard IV);
    - loads a..h from the same value;
    - sets chain_ok = 1 and clears blocks_done.
  - next_state with chain_ok = 1: loads a..h from H.
  - next_state with chain_ok = 0: ignored; no state change.
  - On either accepted start:
    - message_block is captured into the 16-word schedule window;
    - status and valid_block go to 0;
    - round counter t = 0; move to ROUNDS.
  - Inputs may change freely after the accepting edge.
- ROUNDS:
  - Each cycle applies UNROLL sequential rounds (t .. t+UNROLL-1) using K[t] and W[t].
  - W[t] for t ≥ 16 is generated in the sliding 16-word window: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - t increments by UNROLL.
  - After 64/UNROLL cycles, move to DONE.
- DONE (one cycle):
  - Hi ← Hi + working var, each mod 2^32.
  - blocks_done increments, saturating at all-ones.
  - Move to IDLE.
- Completion:
  - First cycle back in IDLE: status = 1, valid_block = 1.
  - Latency: status is seen high 64/UNROLL + 2 edges after the accepting edge (66 for UNROLL = 1; 10 for UNROLL = 8).
- hash output:
  - Registered from H; stable while in IDLE.
  - SHA-224: hash[255:32] = H0..H6 and hash[31:0] = 0; H7 is retained internally for chaining.
  - next_state uses the mode latched at the last first_state; mode input is ignored on next_state.
- Starts while busy: first_state/next_state asserted while status = 0 are ignored; not queued.
- Arithmetic: all additions mod 2^32; Σ/σ/Ch/Maj per FIPS 180-4; K constants held in a combinational ROM.
- After reset mid-operation, chain_ok = 0, so next_state is ignored until a first_state is accepted.

Test Plan:
1. UNROLL = 1, first_state, use_ext_iv = 0, mode = 0, block = 61626380 00…00 00000018 ("abc"):
   - hash = BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
   - status high exactly 66 edges after start; valid_block = 1; blocks_done = 1.
2. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first_state then next_state:
   - intermediate hash = 85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A;
   - final hash = 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
   - blocks_done = 2.
3. mode = 1, "abc" block:
   - hash[255:32] = 23097D223405D8228642A477BDA255B32AADBCE4BDA0B3F7E36C9DA7;
   - hash[31:0] = 0.
4. UNROLL = 4 and UNROLL = 8 instances, scenario 1 stimulus:
   - identical hash to scenario 1;
   - status high after 18 and 10 edges respectively.
5. use_ext_iv = 1 with initial_state = 6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19, "abc" block:
   - same hash as scenario 1.
   - Separately, next_state straight after reset: ignored; status stays 1, valid_block = 0, hash = 0.
6. Reset and busy handling:
   - Assert reset_n = 0 for one edge during ROUNDS (t = 20): next cycle status = 1, valid_block = 0, hash = 0, blocks_done = 0.
   - A subsequent "abc" run still produces the scenario 1 hash.
   - first_state pulsed mid-ROUNDS is ignored: result unchanged and only one completion.
